// File: rtl/mult_pkg.sv
// Shared types and width helpers for the iterative multiplier.
// State encoding plus digit-count and product-width derivations.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int num_digits(int w2, int dw);
    return w2 / dw;
  endfunction

  function automatic int cnt_width(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int prod_width(int w1, int w2);
    return w1 + w2;
  endfunction

endpackage

// File: rtl/iter_multiplier_wrapper_if.sv
// Operand/result handshake bundle for the iterative multiplier.
// master = operand source and result consumer, slave = multiplier.
interface iter_multiplier_wrapper_if #(
  parameter int INPUT1_WIDTH = 64,
  parameter int INPUT2_WIDTH = 64
);
  logic                                 in_valid;
  logic                                 in_ready;
  logic [INPUT1_WIDTH-1:0]              in0;
  logic [INPUT2_WIDTH-1:0]              in1;
  logic                                 signed_mode;
  logic                                 out_valid;
  logic                                 out_ready;
  logic [INPUT1_WIDTH+INPUT2_WIDTH-1:0] outp;
  logic                                 busy;

  modport master (
    output in_valid, in0, in1, signed_mode, out_ready,
    input  in_ready, out_valid, outp, busy
  );

  modport slave (
    input  in_valid, in0, in1, signed_mode, out_ready,
    output in_ready, out_valid, outp, busy
  );
endinterface

// File: rtl/mult_digit_pp.sv
// Combinational multiplicand x one multiplier digit partial product.
// Output is wide enough that the product never truncates.
module mult_digit_pp #(
  parameter int A_WIDTH = 64,
  parameter int D_WIDTH = 4
) (
  input  logic [A_WIDTH-1:0]         a_i,
  input  logic [D_WIDTH-1:0]         d_i,
  output logic [A_WIDTH+D_WIDTH-1:0] pp_o
);
  localparam int PW = A_WIDTH + D_WIDTH;

  assign pp_o = PW'(a_i) * PW'(d_i);
endmodule

// File: rtl/iter_multiplier_wrapper.sv
// Handshaked digit-serial multiplier, unsigned or signed per operation.
// Works on magnitudes and negates the full-width sum at the end.
module iter_multiplier_wrapper
  import mult_pkg::*;
#(
  parameter int INPUT1_WIDTH = 64,
  parameter int INPUT2_WIDTH = 64,
  parameter int DIGIT_WIDTH  = 4
) (
  input logic                 clk,
  input logic                 rst,
  iter_multiplier_wrapper_if.slave bus
);
  localparam int PW  = prod_width(INPUT1_WIDTH, INPUT2_WIDTH);
  localparam int ND  = num_digits(INPUT2_WIDTH, DIGIT_WIDTH);
  localparam int CW  = cnt_width(ND);
  localparam int PPW = INPUT1_WIDTH + DIGIT_WIDTH;

  state_t                  state_q, state_d;
  logic [INPUT1_WIDTH-1:0] mag0_q, mag0_d;
  logic [INPUT2_WIDTH-1:0] mag1_q, mag1_d;
  logic                    sign_q, sign_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PW-1:0]           acc_q, acc_d;
  logic [PW-1:0]           outp_q, outp_d;

  logic [DIGIT_WIDTH-1:0]  digit;
  logic [PPW-1:0]          pp;
  logic [PW-1:0]           acc_sum;
  logic                    last;

  assign digit = mag1_q[int'(cnt_q)*DIGIT_WIDTH +: DIGIT_WIDTH];

  mult_digit_pp #(
    .A_WIDTH (INPUT1_WIDTH),
    .D_WIDTH (DIGIT_WIDTH)
  ) u_pp (
    .a_i  (mag0_q),
    .d_i  (digit),
    .pp_o (pp)
  );

  assign acc_sum = acc_q + (PW'(pp) << (int'(cnt_q) * DIGIT_WIDTH));
  assign last    = (cnt_q == CW'(ND - 1));

  always_comb begin
    state_d = state_q;
    mag0_d  = mag0_q;
    mag1_d  = mag1_q;
    sign_d  = sign_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    outp_d  = outp_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mag0_d  = (bus.signed_mode && bus.in0[INPUT1_WIDTH-1])
                  ? -bus.in0 : bus.in0;
          mag1_d  = (bus.signed_mode && bus.in1[INPUT2_WIDTH-1])
                  ? -bus.in1 : bus.in1;
          sign_d  = bus.signed_mode &
                    (bus.in0[INPUT1_WIDTH-1] ^ bus.in1[INPUT2_WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        acc_d = acc_sum;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          outp_d  = sign_q ? -acc_sum : acc_sum;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      mag0_q  <= '0;
      mag1_q  <= '0;
      sign_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      outp_q  <= '0;
    end else begin
      state_q <= state_d;
      mag0_q  <= mag0_d;
      mag1_q  <= mag1_d;
      sign_q  <= sign_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      outp_q  <= outp_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.outp      = outp_q;
endmodule

// File: tb/tb_iter_multiplier_wrapper.sv
// Directed bench: default build plus DIGIT_WIDTH=1 and 16 instances
// checked against a 128-bit reference product.
module tb_iter_multiplier_wrapper;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  iter_multiplier_wrapper_if #(.INPUT1_WIDTH(64), .INPUT2_WIDTH(64)) bus ();
  iter_multiplier_wrapper_if #(.INPUT1_WIDTH(64), .INPUT2_WIDTH(64)) bus1 ();
  iter_multiplier_wrapper_if #(.INPUT1_WIDTH(64), .INPUT2_WIDTH(64)) bus16 ();

  iter_multiplier_wrapper #(
    .INPUT1_WIDTH(64), .INPUT2_WIDTH(64), .DIGIT_WIDTH(4)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  iter_multiplier_wrapper #(
    .INPUT1_WIDTH(64), .INPUT2_WIDTH(64), .DIGIT_WIDTH(1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  iter_multiplier_wrapper #(
    .INPUT1_WIDTH(64), .INPUT2_WIDTH(64), .DIGIT_WIDTH(16)
  ) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    logic [63:0]  a;
    logic [63:0]  b;
    logic         s;
    logic [127:0] exp;
  } vec_t;

  vec_t vt[8];

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(logic [63:0] a, logic [63:0] b,
                                           logic s);
    logic [127:0] x, y;
    if (s) begin
      x = {{64{a[63]}}, a};
      y = {{64{b[63]}}, b};
    end else begin
      x = {64'd0, a};
      y = {64'd0, b};
    end
    return x * y;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(logic [63:0] a, logic [63:0] b, logic s);
    chk("accept_ready", bus.in_ready, 1'b1);
    bus.in0         = a;
    bus.in1         = b;
    bus.signed_mode = s;
    bus.in_valid    = 1'b1;
    tick();
    bus.in_valid    = 1'b0;
    bus.in0         = {$urandom, $urandom};
    bus.in1         = {$urandom, $urandom};
    bus.signed_mode = ~s;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      tick();
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("hs_out_valid", bus.out_valid, 1'b0);
    chk("hs_in_ready", bus.in_ready, 1'b1);
    chk("hs_busy", bus.busy, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat, l1, l16;
    logic [63:0] a, b;
    logic        s;

    vt[0] = '{64'd3, 64'd5, 1'b0, 128'd15};
    vt[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};
    vt[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF};
    vt[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
              128'h4000_0000_0000_0000_0000_0000_0000_0000};
    vt[4] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFEB};
    vt[5] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 1'b0,
              128'h0000_0000_0000_0002_FFFF_FFFF_FFFF_FFEB};
    vt[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              128'd1};
    vt[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
              128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001};

    bus.in_valid = 1'b0;  bus.out_ready = 1'b0;
    bus.in0 = '0;  bus.in1 = '0;  bus.signed_mode = 1'b0;
    bus1.in_valid = 1'b0;  bus1.out_ready = 1'b0;
    bus1.in0 = '0;  bus1.in1 = '0;  bus1.signed_mode = 1'b0;
    bus16.in_valid = 1'b0;  bus16.out_ready = 1'b0;
    bus16.in0 = '0;  bus16.in1 = '0;  bus16.signed_mode = 1'b0;

    rst = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", bus.in_ready, 1'b1);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_outp", bus.outp, 128'd0);
    rst = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      accept(vt[i].a, vt[i].b, vt[i].s);
      chk("calc_busy", bus.busy, 1'b1);
      wait_done(lat);
      chk("vec_latency", lat, 16);
      chk("vec_outp", bus.outp, vt[i].exp);
      handshake();
    end

    // Backpressure: product held, new operands refused while in DONE.
    accept(64'd3, 64'd5, 1'b0);
    wait_done(lat);
    chk("bp_latency", lat, 16);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in0      = 64'd9;
      tick();
      chk("bp_out_valid", bus.out_valid, 1'b1);
      chk("bp_outp", bus.outp, 128'd15);
      chk("bp_in_ready", bus.in_ready, 1'b0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    accept(64'd2, 64'd3, 1'b0);
    chk("hold_outp_calc", bus.outp, 128'd15);
    bus.out_ready = 1'b1;
    wait_done(lat);
    chk("early_ready_latency", lat, 16);
    chk("early_ready_outp", bus.outp, 128'd6);
    tick();
    bus.out_ready = 1'b0;
    chk("early_ready_drop", bus.out_valid, 1'b0);

    // Reset while the counter sits at digit 7.
    accept(64'd5, 64'd5, 1'b0);
    repeat (7) tick();
    rst = 1'b0;
    tick();
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    chk("midrst_outp", bus.outp, 128'd0);
    rst = 1'b1;
    accept(64'd2, 64'd2, 1'b0);
    wait_done(lat);
    chk("post_rst_latency", lat, 16);
    chk("post_rst_outp", bus.outp, 128'd4);
    handshake();

    // Narrow and wide digit builds against the reference product.
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        a = 64'h8000_0000_0000_0000;  b = a;  s = 1'b1;
      end else if (i == 1) begin
        a = 64'hFFFF_FFFF_FFFF_FFFF;  b = a;  s = 1'b0;
      end else begin
        a = {$urandom, $urandom};  b = {$urandom, $urandom};  s = i[0];
      end
      bus1.in0 = a;   bus1.in1 = b;   bus1.signed_mode = s;
      bus16.in0 = a;  bus16.in1 = b;  bus16.signed_mode = s;
      bus1.in_valid = 1'b1;
      bus16.in_valid = 1'b1;
      tick();
      bus1.in_valid = 1'b0;
      bus16.in_valid = 1'b0;
      bus1.in0 = '0;  bus16.in1 = '1;
      l1 = -1;
      l16 = -1;
      for (int c = 1; c <= 100; c++) begin
        tick();
        if (bus1.out_valid && l1 < 0) l1 = c;
        if (bus16.out_valid && l16 < 0) l16 = c;
        if (l1 >= 0 && l16 >= 0) break;
      end
      chk("dw1_latency", l1, 64);
      chk("dw16_latency", l16, 4);
      chk("dw1_outp", bus1.outp, ref_mul(a, b, s));
      chk("dw16_outp", bus16.outp, ref_mul(a, b, s));
      bus1.out_ready = 1'b1;
      bus16.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      bus16.out_ready = 1'b0;
      chk("dw1_idle", bus1.in_ready, 1'b1);
      chk("dw16_idle", bus16.in_ready, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
